// File: rtl/qflop_c_req_driver.sv
// Four-phase handshake master driving the request inputs of a Muller C-element and checking its hold behaviour.
// Optional wait-state timeout is enabled by defining QFLOP_REQ_TIMEOUT_EN.
module qflop_c_req_driver #(
    parameter int unsigned N           = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STAGGER     = 1,
    parameter int unsigned LAT_W       = 8,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             c_out,
    output logic [N-1:0]     req,
    output logic             busy,
    output logic             done,
    output logic [LAT_W-1:0] lat,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ALL_ONES = '1;

    // Elaboration-time parameter range checks
    if (N < 2 || N > 8) begin : g_bad_n
        $error("N must be in 2..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_WAIT_HI,
        S_FALL,
        S_WAIT_LO,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    logic [IDX_W-1:0]       idx;
    logic [LAT_W-1:0]       cnt;

`ifdef QFLOP_REQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]        tcnt;
`endif

    assign ack_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sync     <= '0;
            idx      <= '0;
            cnt      <= '0;
            req      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lat      <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
`ifdef QFLOP_REQ_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], c_out};
            done <= 1'b0;

            // Latency runs from the cycle after req[0] rises; saturates instead of wrapping
            if ((state == S_RISE || state == S_WAIT_HI) && req[0] && cnt != '1) begin
                cnt <= cnt + LAT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RISE;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end

                S_RISE: begin
                    if (ack_s) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= 2'b01;
                        busy     <= 1'b0;
                    end else if (STAGGER != 0) begin
                        req <= req | (N'(1) << idx);
                        if (idx == IDX_W'(N - 1)) begin
                            state <= S_WAIT_HI;
                            idx   <= '0;
`ifdef QFLOP_REQ_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        req   <= ALL_ONES;
                        state <= S_WAIT_HI;
`ifdef QFLOP_REQ_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                end

                S_WAIT_HI: begin
                    if (ack_s) begin
                        lat   <= cnt;
                        state <= S_FALL;
                        idx   <= '0;
                    end
`ifdef QFLOP_REQ_TIMEOUT_EN
                    else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        busy     <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
`endif
                end

                // The C-element must hold its output high until every input is low
                S_FALL: begin
                    if (!ack_s) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        busy     <= 1'b0;
                    end else if (STAGGER != 0) begin
                        req <= req & ~(N'(1) << idx);
                        if (idx == IDX_W'(N - 1)) begin
                            state <= S_WAIT_LO;
                            idx   <= '0;
`ifdef QFLOP_REQ_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        req   <= '0;
                        state <= S_WAIT_LO;
`ifdef QFLOP_REQ_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end
                end

                S_WAIT_LO: begin
                    if (!ack_s) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
`ifdef QFLOP_REQ_TIMEOUT_EN
                    else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        state    <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        busy     <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
`endif
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                S_ERROR: begin
                    req <= '0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qflop_c_req_driver.sv
// Bench for qflop_c_req_driver: C-element behavioural models (ideal/OR/AND/stuck-0) with random delay, plus a STAGGER=0 instance.
module tb_qflop_c_req_driver;

    localparam int unsigned N    = 5;
    localparam int unsigned SYNC = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, start0;
    logic         c_out, c_out0;
    logic [N-1:0] req, req0;
    logic         busy, busy0, done, done0, err, err0;
    logic [7:0]   lat, lat0;
    logic [1:0]   err_code, err_code0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    int         mode;   // 0 ideal C, 1 OR, 2 AND without hold, 3 stuck at 0
    int         dly;
    logic       cst, cst0;
    logic [7:0] hist;

    always #5 clk = ~clk;

    qflop_c_req_driver #(.N(N), .SYNC_STAGES(SYNC), .STAGGER(1), .LAT_W(8), .TIMEOUT(255)) u_dut (
        .clk(clk), .reset(reset), .start(start), .c_out(c_out), .req(req), .busy(busy),
        .done(done), .lat(lat), .err(err), .err_code(err_code)
    );

    qflop_c_req_driver #(.N(N), .SYNC_STAGES(SYNC), .STAGGER(0), .LAT_W(8), .TIMEOUT(255)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .c_out(c_out0), .req(req0), .busy(busy0),
        .done(done0), .lat(lat0), .err(err0), .err_code(err_code0)
    );

    // C-element models update just after each edge, i.e. zero delay as seen by the synchronizer
    always @(posedge clk) begin
        #1;
        if (reset) begin
            cst  = 1'b0;
            cst0 = 1'b0;
            hist = '0;
        end else begin
            case (mode)
                0: begin
                    if (&req) cst = 1'b1;
                    else if (req == '0) cst = 1'b0;
                end
                1: cst = |req;
                2: cst = &req;
                default: cst = 1'b0;
            endcase
            if (&req0) cst0 = 1'b1;
            else if (req0 == '0) cst0 = 1'b0;
        end
        hist   = {hist[6:0], cst};
        c_out  = hist[dly];
        c_out0 = cst0;
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One full handshake against the ideal C-element delayed by d cycles
    task automatic run_hs(input int d, input bit spurious);
        int n;
        int dc0;
        logic [N-1:0] e;
        mode = 0;
        dly  = d;
        dc0  = done_cnt;
        pulse_start();
        n = 0;
        while (req == '0 && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < int'(N); k++) begin
            e = N'((32'd2 << k) - 1);
            chk("rise_step", 32'(req), 32'(e));
            @(negedge clk);
        end
        n = 0;
        while (req == '1 && n < 40) begin
            if (spurious) start = 1'($urandom % 2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            e = N'(32'h1f << (k + 1));
            chk("fall_step", 32'(req), 32'(e));
            @(negedge clk);
        end
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("done_seen", 32'(done), 32'd1);
        chk("lat", 32'(lat), 32'((N - 1) + SYNC + d));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("err_clean", 32'(err), 32'd0);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [N-1:0] first;

        reset = 1'b1; start = 1'b0; start0 = 1'b0;
        mode = 0; dly = 0; cst = 1'b0; cst0 = 1'b0; hist = '0;
        c_out = 1'b0; c_out0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lat", 32'(lat), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_req0", 32'(req0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Ideal zero-delay handshake, then randomised C-element delays with start noise in WAIT_HI
        run_hs(0, 1'b0);
        for (int i = 0; i < 6; i++) run_hs(int'($urandom_range(0, 4)), 1'(i % 2));

        // OR-style C-element fires early
        mode = 1; dly = 0;
        pulse_start();
        n = 0;
        while (!err && n < 30) begin @(negedge clk); n++; end
        chk("or_err", 32'(err), 32'd1);
        chk("or_code", 32'(err_code), 32'd1);
        chk("or_busy", 32'(busy), 32'd0);
        chk("or_req_partial", 32'(req == '1), 32'd0);
        @(negedge clk);
        chk("or_req_cleared", 32'(req), 32'd0);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("err_sticky_req", 32'(req), 32'd0);
        chk("err_sticky_busy", 32'(busy), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);
        mode = 0;
        do_reset();
        chk("err_after_rst", 32'(err), 32'd0);
        chk("code_after_rst", 32'(err_code), 32'd0);

        // AND without hold releases early
        mode = 2;
        pulse_start();
        n = 0;
        while (!err && n < 40) begin @(negedge clk); n++; end
        chk("and_err", 32'(err), 32'd1);
        chk("and_code", 32'(err_code), 32'd2);
        chk("and_req_partial", 32'(req), 32'(N'(32'h1f << (SYNC + 1))));
        mode = 0;
        do_reset();

        // Reset while parked in WAIT_HI
        mode = 3;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("wait_hi_busy", 32'(busy), 32'd1);
        do_reset();
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        run_hs(1, 1'b0);

        // Stuck-at-0 C-element
        mode = 3;
        pulse_start();
        repeat (1000) @(negedge clk);
`ifdef QFLOP_REQ_TIMEOUT_EN
        chk("to_err", 32'(err), 32'd1);
        chk("to_code", 32'(err_code), 32'd3);
`else
        chk("noto_busy", 32'(busy), 32'd1);
        chk("noto_err", 32'(err), 32'd0);
`endif
        mode = 0;
        do_reset();

        // STAGGER=0: one-cycle rise, back-to-back handshakes from a held start
        first = '0; seen = 0; n = 0;
        @(negedge clk) start0 = 1'b1;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (first == '0 && req0 != '0) first = req0;
            if (done0) begin
                seen++;
                chk("s0_lat", 32'(lat0), 32'(SYNC));
                if (seen == 2) start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        chk("s0_first_req", 32'(first), 32'h1f);
        chk("s0_done_pulses", 32'(seen), 32'd2);
        repeat (6) @(negedge clk);
        chk("s0_idle_busy", 32'(busy0), 32'd0);
        chk("s0_idle_req", 32'(req0), 32'd0);
        chk("s0_err", 32'(err0), 32'd0);
        chk("s0_code", 32'(err_code0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
